// File: rtl/neuron_host_loader_pkg.sv
// Shared types and constants for the neuron host loader.
package neuro_pkg;
  typedef enum logic [2:0] {IDLE, SEND_CNT, SEND_BEGIN, LOAD, RUN, READ, FINISH} state_t;
  localparam logic [63:0] BEGIN_WR         = '1;
  localparam int          WORDS_PER_NEURON = 4;
  localparam int          HDR_DLY          = 2;
endpackage

// File: rtl/neuron_host_loader_if.sv
// Host config stream, chip data bus and readout stream of the loader.
interface neuron_host_loader_if #(
  parameter int FP_DATA_WIDTH = 16
);
  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [FP_DATA_WIDTH-1:0] cfg_data;
  logic [FP_DATA_WIDTH-1:0] ins;
  logic                     rd;
  logic [FP_DATA_WIDTH-1:0] outs;
  logic                     readDone;
  logic                     res_valid;
  logic [FP_DATA_WIDTH-1:0] res_data;
  logic                     res_last;

  modport slave (
    input  cfg_valid, cfg_data, outs, readDone,
    output cfg_ready, ins, rd, res_valid, res_data, res_last
  );
  modport master (
    output cfg_valid, cfg_data, outs, readDone,
    input  cfg_ready, ins, rd, res_valid, res_data, res_last
  );
endinterface

// File: rtl/neuron_host_loader_pacer.sv
// Per-word hold counter; freezes on its last hold cycle until a new word is taken.
module loader_pacer #(
  parameter int WORD_HOLD = 2
) (
  input  logic clk,
  input  logic reset_l,
  input  logic arm,
  input  logic take,
  output logic at_last,
  output logic at_last_n
);
  localparam int HW = (WORD_HOLD > 1) ? $clog2(WORD_HOLD) : 1;
  localparam logic [HW-1:0] LAST = HW'(WORD_HOLD - 1);

  logic [HW-1:0] h, h_n;

  // arm parks the counter on LAST so the first word is due immediately
  always_comb begin
    h_n = h;
    if (arm)            h_n = LAST;
    else if (take)      h_n = '0;
    else if (h != LAST) h_n = h + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_l) h <= '0;
    else          h <= h_n;
  end

  assign at_last   = (h == LAST);
  assign at_last_n = (h_n == LAST);
endmodule

// File: rtl/neuron_host_loader.sv
// Sequences count/begin/config words onto the chip bus, waits the anneal, streams readout back.
// Optional READ timeout when NEURON_LOADER_TIMEOUT_EN is defined.
module neuron_host_loader
  import neuro_pkg::*;
#(
  parameter int FP_DATA_WIDTH   = 16,
  parameter int NEURON_ID_WIDTH = 8,
  parameter int WORD_HOLD       = 2,
  parameter int RUN_CNT_WIDTH   = 24
) (
  input  logic                       clk,
  input  logic                       reset_l,
  input  logic                       start,
  input  logic [NEURON_ID_WIDTH-1:0] num_neurons,
  input  logic [RUN_CNT_WIDTH-1:0]   run_cycles,
  neuron_host_loader_if.slave        bus,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);
  localparam int WCW = NEURON_ID_WIDTH + 2;
`ifdef NEURON_LOADER_TIMEOUT_EN
  localparam int RDW = 16;
`else
  localparam int RDW = 2;
`endif

  state_t state, state_n;
  logic [NEURON_ID_WIDTH-1:0] n_q, n_n;
  logic [RUN_CNT_WIDTH-1:0]   run_q, run_n;
  logic [WCW-1:0]             wcnt_q, wcnt_n, total;
  logic [RDW-1:0]             rdc_q, rdc_n;
  logic [FP_DATA_WIDTH-1:0]   ins_q, ins_n, rdat_q, rdat_n;
  logic snd_q, snd_n, rd_q, rd_n, rdy_q, rdy_n, rval_q, rval_n, rlast_q, rlast_n;
  logic busy_q, busy_n, done_q, done_n, err_q, err_n;
  logic loading, take, hold_last, hold_last_n, capture;

  assign loading = (state == SEND_BEGIN) || (state == LOAD);
  assign take    = rdy_q & bus.cfg_valid;
  assign total   = WCW'(WORDS_PER_NEURON) * WCW'(n_q);
  assign capture = (rdc_q >= RDW'(HDR_DLY));

  loader_pacer #(.WORD_HOLD(WORD_HOLD)) u_pacer (
    .clk       (clk),
    .reset_l   (reset_l),
    .arm       (!loading),
    .take      (take),
    .at_last   (hold_last),
    .at_last_n (hold_last_n)
  );

  always_ff @(posedge clk) begin
    if (!reset_l) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    n_n     = n_q;
    run_n   = run_q;
    wcnt_n  = wcnt_q;
    snd_n   = snd_q;
    rdc_n   = rdc_q;
    ins_n   = ins_q;
    rdat_n  = rdat_q;
    err_n   = err_q;
    rd_n    = 1'b0;
    rval_n  = 1'b0;
    rlast_n = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        ins_n = '0;
        if (start && (num_neurons != '0)) begin
          state_n = SEND_CNT;
          n_n     = num_neurons;
          run_n   = run_cycles;
          wcnt_n  = '0;
          snd_n   = 1'b0;
          ins_n   = FP_DATA_WIDTH'(num_neurons);
        end
      end
      SEND_CNT: begin
        snd_n = 1'b1;
        if (snd_q) begin
          state_n = SEND_BEGIN;
          ins_n   = BEGIN_WR[FP_DATA_WIDTH-1:0];
        end
      end
      SEND_BEGIN, LOAD: begin
        if (take) begin
          ins_n  = bus.cfg_data;
          wcnt_n = wcnt_q + 1'b1;
        end
        // a due word with no data is an underrun; ins and the pacer just hold
        if (rdy_q && !bus.cfg_valid) err_n = 1'b1;
        if (state == SEND_BEGIN) state_n = LOAD;
        else if ((wcnt_q == total) && hold_last) begin
          state_n = RUN;
          ins_n   = '0;
        end
      end
      RUN: begin
        if (run_q <= RUN_CNT_WIDTH'(1)) begin
          state_n = READ;
          rd_n    = 1'b1;
          rdc_n   = '0;
        end else begin
          run_n = run_q - 1'b1;
        end
      end
      READ: begin
        rd_n  = 1'b1;
        rdc_n = (&rdc_q) ? rdc_q : rdc_q + 1'b1;
        if (capture) begin
          rval_n  = 1'b1;
          rdat_n  = bus.outs;
          rlast_n = bus.readDone;
        end
        if (capture && bus.readDone) begin
          rd_n    = 1'b0;
          done_n  = 1'b1;
          state_n = FINISH;
        end
`ifdef NEURON_LOADER_TIMEOUT_EN
        else if (rdc_q == 16'hFFFE) begin
          rd_n    = 1'b0;
          done_n  = 1'b1;
          err_n   = 1'b1;
          state_n = FINISH;
        end
`endif
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
    rdy_n  = ((state_n == SEND_BEGIN) || (state_n == LOAD)) && hold_last_n && (wcnt_n < total);
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      n_q <= '0; run_q <= '0; wcnt_q <= '0; snd_q <= 1'b0; rdc_q <= '0;
      ins_q <= '0; rdat_q <= '0; rd_q <= 1'b0; rdy_q <= 1'b0; rval_q <= 1'b0;
      rlast_q <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0;
    end else begin
      n_q <= n_n; run_q <= run_n; wcnt_q <= wcnt_n; snd_q <= snd_n; rdc_q <= rdc_n;
      ins_q <= ins_n; rdat_q <= rdat_n; rd_q <= rd_n; rdy_q <= rdy_n; rval_q <= rval_n;
      rlast_q <= rlast_n; busy_q <= busy_n; done_q <= done_n; err_q <= err_n;
    end
  end

  assign bus.ins       = ins_q;
  assign bus.rd        = rd_q;
  assign bus.cfg_ready = rdy_q;
  assign bus.res_valid = rval_q;
  assign bus.res_data  = rdat_q;
  assign bus.res_last  = rlast_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
endmodule

// File: doc/neuron_host_loader.md
NEURON_HOST_LOADER -- requirements
Module: neuron_host_loader

Interface
REQ-001 Parameter FP_DATA_WIDTH, default 16, width of the chip data bus words.
REQ-002 Parameter NEURON_ID_WIDTH, default 8, width of the neuron count/index.
REQ-003 Parameter WORD_HOLD, default 2, clk cycles each configuration word is held on ins.
REQ-004 Parameter RUN_CNT_WIDTH, default 24, width of the anneal-duration counter.
REQ-005 Ports: clk  in  1  sole clock; one clock; reset is synchronous and active-low (reset_l  in  1).
REQ-006 Ports: start  in  1 (begin a job); num_neurons  in  NEURON_ID_WIDTH (active neuron count N); run_cycles  in  RUN_CNT_WIDTH (anneal length).
REQ-007 Ports: cfg_valid  in  1, cfg_ready  out  1, cfg_data  in  FP_DATA_WIDTH: per-neuron words in the order Vmem, Mu, NeuronI, Q.
REQ-008 Ports: ins  out  FP_DATA_WIDTH (chip data bus), rd  out  1 (chip readout request), outs  in  FP_DATA_WIDTH (chip readout word), readDone  in  1 (chip last readout word).
REQ-009 Ports: res_valid  out  1, res_data  out  FP_DATA_WIDTH, res_last  out  1 (readout words to host); busy  out  1; done  out  1 (one-cycle pulse); err  out  1 (sticky).

Function
REQ-010 States: IDLE, SEND_CNT, SEND_BEGIN, LOAD, RUN, READ, FINISH; outputs are registered.
REQ-011 IDLE: ins=0, rd=0, cfg_ready=0; start=1 with num_neurons!=0 latches N and run_cycles and moves to SEND_CNT. start with N=0 is ignored.
REQ-012 SEND_CNT: ins={zero-extend N} for 2 cycles, then SEND_BEGIN.
REQ-013 SEND_BEGIN: ins=all-ones (BEGIN_WR) for exactly 1 cycle, then LOAD.
REQ-014 LOAD: accepts 4*N words. cfg_ready=1 only in the cycle a new word is taken. Each accepted word drives ins for WORD_HOLD cycles.
REQ-015 LOAD stall: if cfg_valid=0 when the next word is due, ins holds the previous word and the hold counter freezes until cfg_valid=1. err is set sticky (underrun).
REQ-016 LOAD ends after the WORD_HOLD-th cycle of word 4*N. The word counter is NEURON_ID_WIDTH+2 bits and never wraps. Then RUN with ins=0.
REQ-017 RUN: rd=0; down-counter loaded with run_cycles, decrements each cycle. run_cycles=0 passes straight to READ the next cycle.
REQ-018 READ: rd=1. Starting the second cycle after entry, each cycle's outs is presented as res_data with res_valid=1.
REQ-019 READ end: the word captured in the cycle readDone=1 carries res_last=1. rd drops the next cycle, then FINISH. Expected word count is (N>>4)+1.
REQ-020 FINISH: done=1 for one cycle, then IDLE. busy=1 in every state except IDLE.
REQ-021 start while busy=1 is ignored. readDone outside READ is ignored.

Reset
REQ-022 reset_l=0 at a clk edge forces IDLE: ins=0, rd=0, cfg_ready=0, res_valid=0, res_last=0, res_data=0, busy=0, done=0, err=0, all counters cleared.
REQ-023 Reset mid-job aborts without draining. After reset is released the host must restart the job.

Configuration
REQ-024 Macro NEURON_LOADER_TIMEOUT_EN. When defined, a 16-bit counter in READ sets err, pulses done and returns to IDLE if readDone has not arrived after 65535 cycles with rd=1. When undefined, READ waits for readDone indefinitely and no counter is built.

Structure
REQ-025 Package neuro_pkg holds the state enum, BEGIN_WR (all-ones), WORDS_PER_NEURON=4, and the readout header delay constant (2).
REQ-026 A single sub-module, loader_pacer, implements the WORD_HOLD hold counter with stall freeze. Everything else stays in neuron_host_loader.

Verification
REQ-027 N=3, WORD_HOLD=2, 12 words always valid -> ins=0x0003 for 2 cycles, then 0xFFFF for 1 cycle, then each word for 2 cycles (24 cycles), then ins=0.
REQ-028 cfg_valid low 5 cycles before word 7 -> word 6 is held 7 cycles, err=1, word order unchanged.
REQ-029 run_cycles=10, N=32, chip model outputs 0xA5A5, 0x5A5A, 0x1234 with readDone on the third -> rd high in the cycle after the 10th RUN cycle; 3 res_valid beats with res_last on 0x1234; done pulse; then IDLE.
REQ-030 reset_l=0 in the middle of LOAD -> the next cycle ins=0, busy=0, cfg_ready=0; a new start with N=1 loads exactly 4 words.
REQ-031 start with N=0, and start pulsed during RUN -> no state change or ignored respectively; busy behaves per REQ-020.
REQ-032 With NEURON_LOADER_TIMEOUT_EN defined and readDone never asserted -> err=1 and a done pulse after 65535 READ cycles. Without the macro -> rd stays high indefinitely.
